// File: rtl/core_test_sequencer_if.sv
// Program-load stream between a program source and the test sequencer.
`timescale 1ns/1ps
interface core_test_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              prog_valid;
   logic              prog_ready;
   logic [DATA_W-1:0] prog_data;
   logic              prog_last;

   modport master (output prog_valid, output prog_data, output prog_last, input prog_ready);
   modport slave  (input prog_valid, input prog_data, input prog_last, output prog_ready);
endinterface

// File: rtl/core_test_sequencer.sv
// Run-control harness for the RV32I core: load a program into instruction
// memory, hold the core in reset, release it and watch for halt or timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | after reset, waiting for start; core held in reset
// LOAD       | accepting program words, one imem write per handshake
// RESET_CORE | holding core_rst for RESET_CYCLES cycles
// RUN        | core running; counting cycles and retired instructions
// DONE       | run finished; status and counters held, core frozen
`timescale 1ns/1ps
module core_test_sequencer #(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 8,
   parameter int                RESET_CYCLES = 2,
   parameter int                TIMEOUT      = 1024,
   parameter logic [DATA_W-1:0] HALT_INSN    = DATA_W'(32'h0000_0073)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   core_test_sequencer_if.slave             prog,
   output logic                             imem_we,
   output logic [ADDR_W-1:0]                imem_addr,
   output logic [DATA_W-1:0]                imem_wdata,
   output logic                             core_rst,
   input  logic                             core_instr_valid,
   input  logic [DATA_W-1:0]                core_instr,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic                             timeout,
   output logic                             load_full,
   output logic [$clog2(TIMEOUT+1)-1:0]     cycle_count,
   output logic [31:0]                      retired_count
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CW-1:0]     TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]     TMO_MAX  = CW'(TIMEOUT);
   localparam logic [RW-1:0]     RST_LOAD = RW'(RESET_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      RESET_CORE = 3'd2,
      RUN        = 3'd3,
      DONE       = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [RW-1:0]     rst_cnt;
   logic              halt_seen;

   assign halt_seen = core_instr_valid && (core_instr == HALT_INSN);

   // Sequencer FSM; every output is registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         ptr             <= '0;
         rst_cnt         <= '0;
         prog.prog_ready <= 1'b0;
         imem_we         <= 1'b0;
         imem_addr       <= '0;
         imem_wdata      <= '0;
         core_rst        <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         timeout         <= 1'b0;
         load_full       <= 1'b0;
         cycle_count     <= '0;
         retired_count   <= '0;
      end else begin
         imem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= LOAD;
                  ptr             <= '0;
                  prog.prog_ready <= 1'b1;
                  core_rst        <= 1'b1;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
                  timeout         <= 1'b0;
                  load_full       <= 1'b0;
                  cycle_count     <= '0;
                  retired_count   <= '0;
               end
            end
            LOAD: begin
               if (prog.prog_valid && prog.prog_ready) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= ptr;
                  imem_wdata <= prog.prog_data;
                  ptr        <= ptr + 1'b1;
                  if (prog.prog_last || (ptr == PTR_LAST)) begin
                     state           <= RESET_CORE;
                     prog.prog_ready <= 1'b0;
                     rst_cnt         <= RST_LOAD;
                     load_full       <= (ptr == PTR_LAST) && !prog.prog_last;
                  end
               end
            end
            RESET_CORE: begin
               if (rst_cnt == '0) begin
                  state    <= RUN;
                  core_rst <= 1'b0;
               end else begin
                  rst_cnt <= rst_cnt - 1'b1;
               end
            end
            RUN: begin
               if (cycle_count != TMO_MAX) cycle_count <= cycle_count + 1'b1;
               if (core_instr_valid) retired_count <= retired_count + 32'd1;
               // Halt takes priority over a timeout landing on the same cycle.
               if (halt_seen) begin
                  state    <= DONE;
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= 1'b1;
                  timeout  <= 1'b0;
               end else if (cycle_count == TMO_LAST) begin
                  state    <= DONE;
                  core_rst <= 1'b1;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pass     <= 1'b0;
                  timeout  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/core_test_sequencer.md
# core_test_sequencer

Synthesizable run-control harness for the single-cycle RV32I core. It accepts a program over a valid/ready stream and writes it into instruction memory. It then holds the core in reset for a programmable number of cycles, releases it, and watches the retire stream for a halt instruction or a cycle timeout. It replaces hand-written reset/delay sequences in benches, and the same logic can run on FPGA with a result readout.

## Interface
- DATA_W, 32, instruction/data word width
- ADDR_W, 8, instruction-memory word-address width (depth 2**ADDR_W)
- RESET_CYCLES, 2, cycles core_rst is held high before run (>=1)
- TIMEOUT, 1024, maximum run cycles before abort (>=1)
- HALT_INSN, 32'h0000_0073, retired encoding that ends the run (ecall)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins load phase (ignored unless IDLE or DONE)
- prog_valid  in  1  program word valid
- prog_ready  out  1  sequencer accepts word
- prog_data  in  DATA_W  program word
- prog_last  in  1  marks final program word
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  instruction-memory word address
- imem_wdata  out  DATA_W  instruction-memory write data
- core_rst  out  1  reset to core, active-high
- core_instr_valid  in  1  core retired an instruction this cycle
- core_instr  in  DATA_W  encoding of retired instruction
- busy  out  1  high in LOAD, RESET_CORE, RUN
- done  out  1  run finished; held until start or rst
- pass  out  1  halt seen before timeout (valid when done)
- timeout  out  1  run aborted by timeout (valid when done)
- load_full  out  1  memory filled without prog_last
- cycle_count  out  $clog2(TIMEOUT+1)  run cycles elapsed
- retired_count  out  32  instructions retired in run, wraps mod 2**32

## Operation
- States: IDLE, LOAD, RESET_CORE, RUN, DONE.
- rst (any state, any cycle) forces the following, and in-flight loads are dropped:
  - state IDLE; core_rst=1
  - prog_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - busy=0, done=0, pass=0, timeout=0, load_full=0
  - cycle_count=0, retired_count=0
- IDLE/DONE + start: go to LOAD. Clear done, pass, timeout, load_full and both counters. Load pointer=0. core_rst stays 1.
- LOAD: prog_ready=1.
  - On a prog_valid & prog_ready handshake, register imem_we=1, imem_addr=pointer, imem_wdata=prog_data, then increment the pointer.
  - If the handshake has prog_last=1, or the pointer equals 2**ADDR_W-1, go to RESET_CORE. In the second case, set load_full=1 unless prog_last is also 1.
  - prog_ready=0 from the cycle after the final handshake.
- RESET_CORE: core_rst=1 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: core_rst=0.
  - cycle_count increments every cycle.
  - retired_count increments on each core_instr_valid.
  - If core_instr_valid & core_instr==HALT_INSN: go to DONE with pass=1. The halt instruction is counted in retired_count.
  - Otherwise, if cycle_count==TIMEOUT-1: go to DONE with timeout=1, pass=0.
  - If halt and timeout occur in the same cycle, halt wins (pass=1, timeout=0).
- DONE: done=1, core_rst=1 (core frozen); counters hold.
- start outside IDLE/DONE: ignored.

## Timing
- imem_we/addr/wdata are registered: one cycle after the handshake. imem_we is a single-cycle pulse per word.
- Back-to-back handshakes allowed (one word per cycle).
- First RUN cycle is RESET_CYCLES+1 cycles after the final load handshake: one cycle for the transition, then the reset hold. core_rst falls on the edge entering RUN.
- Status latency:
  - done, pass and timeout assert on the edge after the terminating RUN cycle.
  - busy falls on that same edge.
- cycle_count saturates at TIMEOUT; it never wraps.

## Test plan
- Load three words (0x00500093, 0x00A00113, 0x00000073) with prog_last on the third; drive retire of each in RUN cycles 0..2.
  - imem writes at addr 0,1,2 each one cycle after handshake.
  - done=1, pass=1, timeout=0, retired_count=3, cycle_count=3.
- Same program, never retire 0x00000073, TIMEOUT=16.
  - done asserts after 16 RUN cycles; timeout=1, pass=0, cycle_count=16.
- Halt retired on RUN cycle TIMEOUT-1: pass=1, timeout=0.
- ADDR_W=2, stream 4 words without prog_last.
  - Writes to addr 0..3, load_full=1, prog_ready drops after the 4th word, enters RESET_CORE.
- Assert rst mid-RUN (cycle 5) → next cycle all outputs at reset values, core_rst=1, state IDLE. A later start reloads cleanly from addr 0.
- RESET_CYCLES=4, prog_valid toggling every other cycle.
  - core_rst high exactly 4 cycles after the last write.
  - start pulses during RUN ignored; start in DONE clears pass/done and re-enters LOAD.
